// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over DATA_W cycles, with single-cycle divide corner cases.
module ex_muldiv_iter #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [DATA_W-1:0]  op1_i,
  input  logic [DATA_W-1:0]  op2_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [DATA_W-1:0]  result_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            op_q;
  logic                  neg_q;
  logic [DATA_W-1:0]     mag2_q;
  logic [2*DATA_W-1:0]   p_q;
  logic [DATA_W-1:0]     fin_q;
  logic [RADDR_W-1:0]    wa_q;
  logic [DATA_W-1:0]     result_q;
  logic [RADDR_W-1:0]    waddr_q;

  // Operand decode at acceptance
  logic              op1_signed, op2_signed, neg1, neg2, neg_d;
  logic              div_zero, div_ovf, fast_d;
  logic [DATA_W-1:0] mag1, mag2, fast_res;

  always_comb begin
    op1_signed = (op_i != 3'd3) && (op_i != 3'd5) && (op_i != 3'd7);
    op2_signed = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    neg1       = op1_signed && op1_i[DATA_W-1];
    neg2       = op2_signed && op2_i[DATA_W-1];
    mag1       = neg1 ? -op1_i : op1_i;
    mag2       = neg2 ? -op2_i : op2_i;
    // Remainder takes the dividend's sign; everything else the sign product.
    neg_d      = (op_i[2] && op_i[1]) ? neg1 : (neg1 ^ neg2);
    div_zero   = op_i[2] && (op2_i == '0);
    div_ovf    = op_i[2] && !op_i[0] && (op1_i == MOST_NEG) && (op2_i == ALL_ONES);
    fast_d     = div_zero || div_ovf;
    fast_res   = '0;
    if (div_zero) fast_res = op_i[1] ? op1_i : ALL_ONES;
    else          fast_res = op_i[1] ? '0    : op1_i;
  end

  // One radix-2 step. p_q low half holds the multiplier / shifting dividend,
  // high half the running partial product / partial remainder.
  logic [DATA_W:0]     mul_sum, rem_sh, diff;
  logic [2*DATA_W-1:0] mul_next, div_next, p_next, prod_fix;
  logic [DATA_W-1:0]   dv_raw, dv_fix, calc_res;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*DATA_W-1:DATA_W]} + {1'b0, (p_q[0] ? mag2_q : '0)};
    mul_next = {mul_sum, p_q[DATA_W-1:1]};
    rem_sh   = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
    diff     = rem_sh - {1'b0, mag2_q};
    div_next = diff[DATA_W] ? {rem_sh[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0}
                            : {diff[DATA_W-1:0],   p_q[DATA_W-2:0], 1'b1};
    p_next   = op_q[2] ? div_next : mul_next;
    prod_fix = neg_q ? -p_next : p_next;
    dv_raw   = op_q[1] ? p_next[2*DATA_W-1:DATA_W] : p_next[DATA_W-1:0];
    dv_fix   = neg_q ? -dv_raw : dv_raw;
    calc_res = '0;
    if (op_q[2])              calc_res = dv_fix;
    else if (op_q[1:0] == 2'd0) calc_res = prod_fix[DATA_W-1:0];
    else                      calc_res = prod_fix[2*DATA_W-1:DATA_W];
  end

  assign busy_o      = (state_q != S_IDLE);
  assign valid_o     = (state_q == S_DONE) && !flush_i && !rst;
  assign reg_we_o    = valid_o;
  assign result_o    = valid_o ? fin_q : result_q;
  assign reg_waddr_o = valid_o ? wa_q  : waddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mag2_q   <= '0;
      p_q      <= '0;
      fin_q    <= '0;
      wa_q     <= '0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      if (valid_o) begin
        result_q <= fin_q;
        waddr_q  <= wa_q;
      end
      if (flush_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              op_q   <= op_i;
              neg_q  <= neg_d;
              mag2_q <= mag2;
              p_q    <= {{DATA_W{1'b0}}, mag1};
              wa_q   <= waddr_i;
              cnt_q  <= '0;
              if (fast_d) begin
                fin_q   <= fast_res;
                state_q <= S_DONE;
              end else begin
                state_q <= S_CALC;
              end
            end
          end
          S_CALC: begin
            p_q <= p_next;
            if (cnt_q == CNT_LAST) begin
              fin_q   <= calc_res;
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed bench for ex_muldiv_iter: hand-computed RV32M results pushed to a
// scoreboard queue, checked by an independent monitor on every valid_o.
module tb_ex_muldiv_iter;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int LAT_N   = DATA_W + 1;
  localparam int LAT_F   = 1;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic [2:0]         op_i = '0;
  logic [DATA_W-1:0]  op1_i = '0;
  logic [DATA_W-1:0]  op2_i = '0;
  logic [RADDR_W-1:0] waddr_i = '0;
  logic               flush_i = 1'b0;
  logic               busy_o, valid_o, reg_we_o;
  logic [DATA_W-1:0]  result_o;
  logic [RADDR_W-1:0] reg_waddr_o;

  ex_muldiv_iter #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .op1_i(op1_i), .op2_i(op2_i), .waddr_i(waddr_i), .flush_i(flush_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o)
  );

  // Clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {expected cycle, waddr, result}
  logic [68:0]       exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] held_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [68:0] e;
    if (!rst && (valid_o || reg_we_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result",  result_o,    64'(e[31:0]));
        chk("waddr",   reg_waddr_o, 64'(e[36:32]));
        chk("latency", 64'(cyc),    64'(e[68:37]));
        chk("valid",   valid_o,     1);
        chk("reg_we",  reg_we_o,    1);
        held_res = e[31:0];
      end
    end
  end

  // Drivers: called at posedge+1 with the DUT idle
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] res, input int lat,
                       input bit push);
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; waddr_i = wa;
    if (push) exp_q.push_back({32'(cyc + lat), wa, res});
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wa, input logic [31:0] res, input int lat);
    issue(op, a, b, wa, res, lat, 1'b1);
    drain(60);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_we", reg_we_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_waddr", reg_waddr_o, 0);

    // Multiplies
    run(MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, LAT_N);
    run(MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, LAT_N);
    run(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF, LAT_N);
    run(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, LAT_N);
    run(MUL,    32'h12345678, 32'h10,       5'd7,  32'h23456780, LAT_N);
    run(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h0,        LAT_N);
    // Divides
    run(DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, LAT_N);
    run(REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, LAT_N);
    run(DIVU,   32'hFFFFFFFF, 32'd2,        5'd11, 32'h7FFFFFFF, LAT_N);
    run(DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       LAT_N);
    run(REMU,   32'd100,      32'd7,        5'd13, 32'd2,        LAT_N);
    run(DIV,    32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, LAT_N);
    run(REM,    32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        LAT_N);
    run(DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h0,        LAT_N);
    run(REMU,   32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, LAT_N);
    // Fast paths: divide by zero and signed overflow
    run(DIV,    32'd12345,    32'd0,        5'd18, 32'hFFFFFFFF, LAT_F);
    run(REMU,   32'd5,        32'd0,        5'd19, 32'd5,        LAT_F);
    run(REM,    32'hFFFFFFF9, 32'd0,        5'd20, 32'hFFFFFFF9, LAT_F);
    run(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, LAT_F);
    run(REM,    32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h0,        LAT_F);

    // Flush at CALC cycle 10, with a second start ignored while busy
    issue(DIV, 32'd100, 32'd7, 5'd25, 32'd0, LAT_N, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    start_i = 1'b1; op_i = MUL; op1_i = 32'd3; op2_i = 32'd0; waddr_i = 5'd26;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", valid_o, 0);
    chk("flush_result_held", result_o, 64'(held_res));
    chk("flush_waddr_held", reg_waddr_o, 22);
    repeat (45) begin @(posedge clk); #1; end
    chk("flush_stays_idle", busy_o, 0);

    // Flush in DONE gates the strobe
    issue(DIVU, 32'd5, 32'd0, 5'd27, 32'd0, LAT_F, 1'b0);
    flush_i = 1'b1;
    #1;
    chk("done_flush_valid", valid_o, 0);
    chk("done_flush_we", reg_we_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("done_flush_busy", busy_o, 0);
    chk("done_flush_result_held", result_o, 64'(held_res));

    // start together with flush in IDLE is dropped
    start_i = 1'b1; flush_i = 1'b1; op_i = MUL; op1_i = 32'd2; op2_i = 32'd2;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("start_flush_busy", busy_o, 0);

    // Reset at DIV cycle 5, then an immediate fresh MUL
    issue(DIV, 32'd1000, 32'd3, 5'd28, 32'd0, LAT_N, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    held_res = '0;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_we", reg_we_o, 0);
    chk("mid_rst_result", result_o, 0);
    chk("mid_rst_waddr", reg_waddr_o, 0);
    run(MUL, 32'd6, 32'd7, 5'd29, 32'd42, LAT_N);

    repeat (5) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_iter.md
EX_MULDIV_ITER -- requirements
Module: ex_muldiv_iter

Interface
Parameters:
REQ-001 SHALL provide parameter DATA_W, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL provide parameter RADDR_W, default 5, register-file address width.
Ports:
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op_i  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port op1_i  input  DATA_W  rs1 operand.
REQ-008 SHALL have port op2_i  input  DATA_W  rs2 operand.
REQ-009 SHALL have port waddr_i  input  RADDR_W  destination register.
REQ-010 SHALL have port flush_i  input  1  abort current operation.
REQ-011 SHALL have port busy_o  output  1  high in CALC/DONE and the cycle start is accepted onward.
REQ-012 SHALL have port valid_o  output  1  one-cycle result strobe.
REQ-013 SHALL have port result_o  output  DATA_W  result, held until next valid_o.
REQ-014 SHALL have port reg_we_o  output  1  equals valid_o.
REQ-015 SHALL have port reg_waddr_o  output  RADDR_W  latched waddr_i, held with result_o.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 IDLE & start_i SHALL latch op_i, operands' magnitudes, sign-fix flag, waddr_i; go CALC (normal) or DONE (fast path); busy_o=1 from next cycle.
REQ-018 CALC SHALL run radix-2 iteration (shift-add multiply on 2*DATA_W product; restoring divide), exactly DATA_W cycles via counter 0..DATA_W-1, then DONE.
REQ-019 DONE SHALL assert valid_o and reg_we_o for exactly one cycle, drive result_o/reg_waddr_o, then IDLE.
REQ-020 Latency: start accepted cycle T -> valid_o at T+DATA_W+1 (normal), T+1 (fast path).
REQ-021 start_i in CALC/DONE SHALL be ignored; no queueing.
REQ-022 Signedness: MUL/MULH/DIV/REM both signed; MULHSU op1 signed, op2 unsigned; MULHU/DIVU/REMU unsigned; signed operands converted to magnitude, result negated if sign flag set.
REQ-023 MUL SHALL return product[DATA_W-1:0]; MULH/MULHSU/MULHU product[2*DATA_W-1:DATA_W].
REQ-024 REM sign SHALL follow dividend; DIV quotient negative iff operand signs differ and quotient nonzero.
REQ-025 Divide-by-zero (op2_i=0, ops 4-7) SHALL fast-path: quotient all ones, remainder = op1_i.
REQ-026 Signed overflow (DIV/REM, op1_i=most-negative, op2_i=all ones) SHALL fast-path: quotient = op1_i, remainder 0.
REQ-027 flush_i SHALL dominate: any state -> IDLE next cycle, no valid_o; result_o/reg_waddr_o keep prior values; start_i with flush_i in same cycle ignored.
REQ-028 flush_i in DONE SHALL suppress that cycle's valid_o/reg_we_o (combinational gate).

Reset
REQ-029 rst SHALL dominate flush_i and start_i; next cycle: state IDLE, counter 0, busy_o 0, valid_o 0, reg_we_o 0, result_o 0, reg_waddr_o 0.
REQ-030 rst mid-CALC SHALL abandon operation with no valid_o; new start accepted first cycle after rst deasserts.

Verification (DATA_W=32)
REQ-031 MUL 7 x -3 -> valid_o exactly 33 cycles after start, result_o 0xFFFFFFEB, reg_waddr_o = waddr_i.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF, 33-cycle latency each.
REQ-034 DIV x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; valid_o 1 cycle after start.
REQ-035 flush_i at cycle 10 of CALC -> no valid_o, busy_o 0 next cycle, result_o unchanged; second start_i while busy ignored.
REQ-036 rst at cycle 5 of DIV -> all outputs 0 next cycle; fresh MUL 6 x 7 after rst -> 42.
